// File: rtl/pe_bfly_pipe.sv
// Unified CT/GS/PWM/ADDSUB butterfly for the ML-KEM polynomial unit.
// All modes share one schedule: pre-op register, MUL_LAT multiplier stages, post-op output register.
module pe_bfly_pipe #(
    parameter int COEFF_W = 12,
    parameter int Q       = 3329,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [2:0]                          mode_i,
    input  logic [COEFF_W-1:0]                  a_i,
    input  logic [COEFF_W-1:0]                  b_i,
    input  logic [COEFF_W-1:0]                  w1_i,
    input  logic [COEFF_W-1:0]                  w2_i,
    input  logic [TAG_W-1:0]                    tag_i,
    input  logic                                flush_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [COEFF_W-1:0]                  u_o,
    output logic [COEFF_W-1:0]                  v_o,
    output logic [TAG_W-1:0]                    tag_o,
    output logic [$clog2(MUL_LAT+4)-1:0]        inflight_o
);
    localparam int LAT   = MUL_LAT + 2;
    localparam int CNT_W = $clog2(LAT + 2);
    localparam int PW    = 2 * COEFF_W;
    localparam logic [COEFF_W:0] QX = (COEFF_W+1)'(Q);
    localparam logic [2:0] MD_CT = 3'd0, MD_GS = 3'd1, MD_GSH = 3'd2, MD_PWM = 3'd3, MD_AS = 3'd4;

    function automatic logic [COEFF_W-1:0] mod_add(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
        logic [COEFF_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return s[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] mod_sub(input logic [COEFF_W-1:0] x, input logic [COEFF_W-1:0] y);
        logic [COEFF_W:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + QX - {1'b0, y};
        return d[COEFF_W-1:0];
    endfunction

    function automatic logic [COEFF_W-1:0] mod_half(input logic [COEFF_W-1:0] x);
        logic [COEFF_W:0] h;
        h = x[0] ? ({1'b0, x} + QX) : {1'b0, x};
        h = h >> 1;
        return h[COEFF_W-1:0];
    endfunction

    logic w_stall, w_en, w_acc, w_cons;
    logic [COEFF_W-1:0] w_x1, w_y1, w_x2, w_y2, w_c, w_e, w_m1, w_m2, w_u, w_v;

    logic                r_s1_v;
    logic [2:0]          r_s1_mode;
    logic [TAG_W-1:0]    r_s1_tag;
    logic [COEFF_W-1:0]  r_s1_x1, r_s1_y1, r_s1_x2, r_s1_y2, r_s1_c, r_s1_e;

    logic                r_mv    [MUL_LAT];
    logic [2:0]          r_mmode [MUL_LAT];
    logic [TAG_W-1:0]    r_mtag  [MUL_LAT];
    logic [COEFF_W-1:0]  r_mc    [MUL_LAT];
    logic [COEFF_W-1:0]  r_me    [MUL_LAT];
    logic [PW-1:0]       r_mp1   [MUL_LAT];
    logic [PW-1:0]       r_mp2   [MUL_LAT];

    logic                r_valid_o;
    logic [COEFF_W-1:0]  r_u, r_v;
    logic [TAG_W-1:0]    r_tag;
    logic [CNT_W-1:0]    r_inflight;

    assign w_stall = r_valid_o & ~ready_i;
    assign w_en    = ~w_stall;
    assign ready_o = ~w_stall & ~flush_i;
    assign w_acc   = valid_i & ready_o;
    assign w_cons  = r_valid_o & ready_i;

    // GS pre-add/sub happens here, so CT's first register is a pure delay ahead of its multiply.
    always_comb begin
        w_x1 = '0; w_y1 = '0; w_x2 = '0; w_y2 = '0; w_c = '0; w_e = '0;
        case (mode_i)
            MD_CT: begin
                w_x1 = b_i; w_y1 = w1_i; w_c = a_i;
            end
            MD_GS, MD_GSH: begin
                w_x1 = mod_sub(b_i, a_i); w_y1 = w1_i; w_c = mod_add(a_i, b_i);
            end
            MD_PWM: begin
                w_x1 = a_i; w_y1 = w1_i; w_x2 = b_i; w_y2 = w2_i;
            end
            MD_AS: begin
                w_c = mod_add(a_i, b_i); w_e = mod_sub(a_i, b_i);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_s1_v    <= 1'b0;
            r_valid_o <= 1'b0;
            for (int k = 0; k < MUL_LAT; k++) r_mv[k] <= 1'b0;
        end else if (w_en) begin
            r_s1_v    <= w_acc;
            r_mv[0]   <= r_s1_v;
            for (int k = 1; k < MUL_LAT; k++) r_mv[k] <= r_mv[k-1];
            r_valid_o <= r_mv[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_mode <= mode_i;  r_s1_tag <= tag_i;
            r_s1_x1   <= w_x1;    r_s1_y1  <= w_y1;
            r_s1_x2   <= w_x2;    r_s1_y2  <= w_y2;
            r_s1_c    <= w_c;     r_s1_e   <= w_e;
            r_mmode[0] <= r_s1_mode;
            r_mtag[0]  <= r_s1_tag;
            r_mc[0]    <= r_s1_c;
            r_me[0]    <= r_s1_e;
            r_mp1[0]   <= PW'(r_s1_x1) * PW'(r_s1_y1);
            r_mp2[0]   <= PW'(r_s1_x2) * PW'(r_s1_y2);
            for (int k = 1; k < MUL_LAT; k++) begin
                r_mmode[k] <= r_mmode[k-1];
                r_mtag[k]  <= r_mtag[k-1];
                r_mc[k]    <= r_mc[k-1];
                r_me[k]    <= r_me[k-1];
                r_mp1[k]   <= r_mp1[k-1];
                r_mp2[k]   <= r_mp2[k-1];
            end
        end
    end

    assign w_m1 = COEFF_W'(r_mp1[MUL_LAT-1] % PW'(Q));
    assign w_m2 = COEFF_W'(r_mp2[MUL_LAT-1] % PW'(Q));

    always_comb begin
        w_u = '0; w_v = '0;
        case (r_mmode[MUL_LAT-1])
            MD_CT: begin
                w_u = mod_add(r_mc[MUL_LAT-1], w_m1);
                w_v = mod_sub(r_mc[MUL_LAT-1], w_m1);
            end
            MD_GS:  begin w_u = r_mc[MUL_LAT-1];           w_v = w_m1;           end
            MD_GSH: begin w_u = mod_half(r_mc[MUL_LAT-1]); w_v = mod_half(w_m1); end
            MD_PWM: begin w_u = w_m1;                      w_v = w_m2;           end
            MD_AS:  begin w_u = r_mc[MUL_LAT-1];           w_v = r_me[MUL_LAT-1]; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_u <= '0; r_v <= '0; r_tag <= '0;
        end else if (w_en) begin
            r_u <= w_u; r_v <= w_v; r_tag <= r_mtag[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) r_inflight <= '0;
        else                r_inflight <= r_inflight + CNT_W'(w_acc) - CNT_W'(w_cons);
    end

    assign valid_o    = r_valid_o;
    assign u_o        = r_u;
    assign v_o        = r_v;
    assign tag_o      = r_tag;
    assign inflight_o = r_inflight;
endmodule

// File: tb/tb_pe_bfly_pipe.sv
// Directed bench for pe_bfly_pipe at Q=3329, MUL_LAT=3 (LAT=5).
module tb_pe_bfly_pipe;
    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [2:0]  mode_i;
    logic [11:0] a_i, b_i, w1_i, w2_i, u_o, v_o;
    logic [3:0]  tag_i, tag_o;
    logic [2:0]  inflight_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { int u; int v; int t; } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    pe_bfly_pipe #(.COEFF_W(12), .Q(Q), .MUL_LAT(3), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
        .a_i(a_i), .b_i(b_i), .w1_i(w1_i), .w2_i(w2_i), .tag_i(tag_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .u_o(u_o), .v_o(v_o), .tag_o(tag_o),
        .inflight_o(inflight_o)
    );

    // Reference arithmetic via plain integer modulo; 1665 is the inverse of 2 mod 3329.
    function automatic void model(input int m, input int a, input int b, input int w1, input int w2,
                                  output int u, output int v);
        int t;
        u = 0; v = 0;
        case (m)
            0: begin t = (b * w1) % Q; u = (a + t) % Q; v = (a - t + Q) % Q; end
            1: begin u = (a + b) % Q; v = (((b - a + Q) % Q) * w1) % Q; end
            2: begin u = (((a + b) % Q) * 1665) % Q; v = (((((b - a + Q) % Q) * w1) % Q) * 1665) % Q; end
            3: begin u = (a * w1) % Q; v = (b * w2) % Q; end
            4: begin u = (a + b) % Q; v = (a - b + Q) % Q; end
            default: begin u = 0; v = 0; end
        endcase
    endfunction

    task automatic drive(input int m, input int a, input int b, input int w1, input int w2, input int t);
        valid_i = 1'b1; mode_i = 3'(m); a_i = 12'(a); b_i = 12'(b);
        w1_i = 12'(w1); w2_i = 12'(w2); tag_i = 4'(t);
    endtask

    task automatic run_single(input int m, input int a, input int b, input int w1, input int w2, input int t,
                              output int u, output int v, output int tg, output int lat);
        @(negedge clk);
        ready_i = 1'b1;
        drive(m, a, b, w1, w2, t);
        @(negedge clk);
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        u = int'(u_o); v = int'(v_o); tg = int'(tag_o);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0); valid_i = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (valid_o !== 1'b0)     begin n_fail++; $display("FAIL reset_valid got %0b want 0", valid_o); end
        n_chk++; if (u_o !== 12'd0)        begin n_fail++; $display("FAIL reset_u got %0d want 0", u_o); end
        n_chk++; if (v_o !== 12'd0)        begin n_fail++; $display("FAIL reset_v got %0d want 0", v_o); end
        n_chk++; if (tag_o !== 4'd0)       begin n_fail++; $display("FAIL reset_tag got %0d want 0", tag_o); end
        n_chk++; if (inflight_o !== 3'd0)  begin n_fail++; $display("FAIL reset_inflight got %0d want 0", inflight_o); end
        rst = 1'b0;
    endtask

    task automatic test_ct();
        int u, v, tg, lat;
        run_single(0, 1, 2, 17, 0, 10, u, v, tg, lat);
        n_chk++; if (lat !== 5)    begin n_fail++; $display("FAIL ct_latency got %0d want 5", lat); end
        n_chk++; if (u !== 35)     begin n_fail++; $display("FAIL ct_u got %0d want 35", u); end
        n_chk++; if (v !== 3296)   begin n_fail++; $display("FAIL ct_v got %0d want 3296", v); end
        n_chk++; if (tg !== 10)    begin n_fail++; $display("FAIL ct_tag got %0d want 10", tg); end
        @(negedge clk);
        n_chk++; if (valid_o !== 1'b0 || inflight_o !== 3'd0)
            begin n_fail++; $display("FAIL ct_drain got valid=%0b inflight=%0d want 0/0", valid_o, inflight_o); end
    endtask

    task automatic test_gs();
        int u, v, tg, lat;
        run_single(2, 3, 1, 1, 0, 3, u, v, tg, lat);
        n_chk++; if (lat !== 5 || u !== 2 || v !== 3328)
            begin n_fail++; $display("FAIL gs_half got lat=%0d u=%0d v=%0d want 5/2/3328", lat, u, v); end
        run_single(1, 3, 1, 1, 0, 4, u, v, tg, lat);
        n_chk++; if (lat !== 5 || u !== 4 || v !== 3327 || tg !== 4)
            begin n_fail++; $display("FAIL gs got lat=%0d u=%0d v=%0d tag=%0d want 5/4/3327/4", lat, u, v, tg); end
    endtask

    task automatic test_pwm_addsub();
        int u, v, tg, lat;
        run_single(3, 3328, 2, 3328, 1665, 5, u, v, tg, lat);
        n_chk++; if (lat !== 5 || u !== 1 || v !== 1)
            begin n_fail++; $display("FAIL pwm got lat=%0d u=%0d v=%0d want 5/1/1", lat, u, v); end
        run_single(4, 3328, 5, 0, 0, 6, u, v, tg, lat);
        n_chk++; if (lat !== 5 || u !== 4 || v !== 3323)
            begin n_fail++; $display("FAIL addsub got lat=%0d u=%0d v=%0d want 5/4/3323", lat, u, v); end
    endtask

    task automatic test_back_to_back();
        int nxt = 0, got = 0, peak = 0;
        int eu, ev;
        exp_t e;
        bit exp_rdy;
        q.delete();
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            ready_i = !(c >= 3 && c <= 6);
            if (nxt < 8) drive(0, nxt * 100 + 1, nxt * 37 + 5, nxt * 411 + 3, 0, nxt);
            else         valid_i = 1'b0;
            #1;
            exp_rdy = !(c == 5 || c == 6);
            n_chk++; if (ready_o !== exp_rdy)
                begin n_fail++; $display("FAIL b2b_ready cycle %0d got %0b want %0b", c, ready_o, exp_rdy); end
            if (int'(inflight_o) > peak) peak = int'(inflight_o);
            if (valid_o && ready_i) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra cycle %0d got tag=%0d want no beat", c, tag_o);
                end else begin
                    e = q.pop_front();
                    if (u_o !== 12'(e.u) || v_o !== 12'(e.v) || tag_o !== 4'(e.t)) begin
                        n_fail++;
                        $display("FAIL b2b_data got u=%0d v=%0d tag=%0d want u=%0d v=%0d tag=%0d",
                                 u_o, v_o, tag_o, e.u, e.v, e.t);
                    end
                end
                got++;
            end
            if (valid_i && ready_o) begin
                model(0, nxt * 100 + 1, nxt * 37 + 5, nxt * 411 + 3, 0, eu, ev);
                q.push_back('{u: eu, v: ev, t: nxt});
                nxt++;
            end
        end
        valid_i = 1'b0;
        n_chk++; if (got !== 8)  begin n_fail++; $display("FAIL b2b_count got %0d want 8", got); end
        n_chk++; if (peak !== 5) begin n_fail++; $display("FAIL b2b_peak got %0d want 5", peak); end
        n_chk++; if (inflight_o !== 3'd0) begin n_fail++; $display("FAIL b2b_inflight_end got %0d want 0", inflight_o); end
    endtask

    task automatic test_mode_cycle();
        int modes[6] = '{0, 1, 3, 4, 2, 6};
        int sent = 0, got = 0, m, a, b, w1, w2, eu, ev;
        exp_t e;
        q.delete();
        for (int c = 0; c < 60 && got < 24; c++) begin
            @(negedge clk);
            ready_i = 1'b1;
            if (sent < 24) begin
                m = modes[sent % 6];
                a = int'($urandom_range(0, Q - 1)); b = int'($urandom_range(0, Q - 1));
                w1 = int'($urandom_range(0, Q - 1)); w2 = int'($urandom_range(0, Q - 1));
                drive(m, a, b, w1, w2, sent % 16);
            end else valid_i = 1'b0;
            #1;
            if (valid_o && ready_i) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL mix_extra got tag=%0d want no beat", tag_o);
                end else begin
                    e = q.pop_front();
                    if (u_o !== 12'(e.u) || v_o !== 12'(e.v) || tag_o !== 4'(e.t)) begin
                        n_fail++;
                        $display("FAIL mix_data got u=%0d v=%0d tag=%0d want u=%0d v=%0d tag=%0d",
                                 u_o, v_o, tag_o, e.u, e.v, e.t);
                    end
                end
                got++;
            end
            if (valid_i && ready_o) begin
                model(m, a, b, w1, w2, eu, ev);
                q.push_back('{u: eu, v: ev, t: sent % 16});
                sent++;
            end
        end
        valid_i = 1'b0;
        n_chk++; if (got !== 24) begin n_fail++; $display("FAIL mix_count got %0d want 24", got); end
    endtask

    task automatic test_abort(input bit use_rst);
        int u, v, tg, lat;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ready_i = 1'b1;
            drive(4, k + 1, k, 0, 0, k + 8);
        end
        @(negedge clk);
        if (use_rst) begin
            valid_i = 1'b0; rst = 1'b1;
        end else begin
            flush_i = 1'b1;
            drive(4, 9, 9, 0, 0, 15);
            #1;
            n_chk++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", ready_o); end
        end
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        n_chk++; if (valid_o !== 1'b0 || inflight_o !== 3'd0)
            begin n_fail++; $display("FAIL abort_%0s got valid=%0b inflight=%0d want 0/0",
                                     use_rst ? "rst" : "flush", valid_o, inflight_o); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_chk++; if (valid_o !== 1'b0 || inflight_o !== 3'd0)
                begin n_fail++; $display("FAIL abort_stale cycle %0d got valid=%0b inflight=%0d want 0/0",
                                         c, valid_o, inflight_o); end
        end
        run_single(4, 100, 200, 0, 0, 7, u, v, tg, lat);
        n_chk++; if (lat !== 5 || u !== 300 || v !== 3229 || tg !== 7)
            begin n_fail++; $display("FAIL abort_recover got lat=%0d u=%0d v=%0d tag=%0d want 5/300/3229/7",
                                     lat, u, v, tg); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ct();
        test_gs();
        test_pwm_addsub();
        test_back_to_back();
        test_mode_cycle();
        test_abort(1'b1);
        test_abort(1'b0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
